conn_loopback_tester: RTL and testbench
=======================================

Name: conn_loopback_tester

Overview:
Parametrised successor to the plain pass-through connector models. It drives walking-one or walking-zero patterns onto NPINS connector pins and checks the looped-back receive side, which exposes opens and shorts during board and backplane bring-up. It sits behind a connector model in board-level benches, and in the TUB test firmware beside the connector under test. Results are a fault count, the first failing step index and the first mismatch vector.

Parameters:
NPINS, 165, number of connector pins under test (2..255)
SETTLE, 4, cycles each pattern is driven before sampling (>=1)
IDXW, 8, width of step index and fault count; must satisfy 2**IDXW > NPINS

Ports:
CLK  input  1  system clock; all state changes on rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  begin a test run; sampled in IDLE only
MODE  input  1  0 = walking-one, 1 = walking-zero; latched at START
ABORT  input  1  terminate a run in progress
DRV  output  NPINS  pattern driven to connector pins
DRV_OE  output  1  drive enable; high while a run is active
RCV  input  NPINS  looped-back pin values
BUSY  output  1  high from the cycle after START until return to IDLE
DONE  output  1  one-cycle pulse on normal completion
PASS  output  1  1 = last completed run had zero faults
FAULT_CNT  output  IDXW  number of failing steps, saturating at 2**IDXW-1
FIRST_IDX  output  IDXW  step index of first failure
FIRST_DIFF  output  NPINS  RCV XOR expected at first failing step

Behaviour:
- Reset values while RESET is high, applied immediately and asynchronously:
  - state IDLE; DRV=0, DRV_OE=0, BUSY=0, DONE=0, PASS=0
  - FAULT_CNT=0, FIRST_IDX=0, FIRST_DIFF=0
  - step index i=0, settle counter 0
- States: IDLE, SETTLE, COMPARE, FINISH.
- IDLE:
  - DRV=0, DRV_OE=0.
  - On START=1: latch MODE, clear FAULT_CNT, FIRST_IDX, FIRST_DIFF and PASS, set i=0, go to SETTLE.
- SETTLE:
  - DRV_OE=1.
  - DRV = (1<<i) for MODE=0, ~(1<<i) for MODE=1.
  - Stays exactly SETTLE cycles (counter runs 0..SETTLE-1), then goes to COMPARE.
- COMPARE (one cycle):
  - DRV unchanged; RCV is sampled directly.
  - diff = RCV ^ DRV.
  - If diff != 0: FAULT_CNT increments (saturating). If this is the first failure of the run, FIRST_IDX=i and FIRST_DIFF=diff.
  - If i == NPINS-1, go to FINISH; otherwise i increments and the state returns to SETTLE.
- FINISH (one cycle):
  - DRV=0, DRV_OE=0, DONE=1.
  - PASS = (FAULT_CNT==0), using the value updated by the last COMPARE.
  - Go to IDLE.
- Timing:
  - BUSY is high in SETTLE, COMPARE and FINISH.
  - START sampled at edge 0 puts DONE high in cycle NPINS*(SETTLE+1)+1.
- START while not in IDLE is ignored.
- ABORT (any non-IDLE state):
  - Go to IDLE at the next edge, with DRV=0 and DRV_OE=0.
  - No DONE pulse; PASS forced to 0.
  - FAULT_CNT, FIRST_IDX and FIRST_DIFF hold their partial values.
  - ABORT has priority over the COMPARE update in the same cycle. ABORT in IDLE has no effect.
- Results and PASS hold until the next accepted START or RESET.
- Saturation: FAULT_CNT never wraps.
- Step index: i never exceeds NPINS-1.
- RCV is not synchronised internally; SETTLE must cover propagation plus any external synchroniser delay.

Decomposition:
- Shared package conn_test_pkg holds:
  - state enumeration (IDLE, SETTLE, COMPARE, FINISH)
  - MODE encodings (WALK_ONE=0, WALK_ZERO=1)
  - default NPINS and SETTLE constants, shared with the CONN* models
- One natural sub-module, conn_step_timer: SETTLE-cycle down-counter with load and expire outputs, instantiated once.
- Pattern generation and compare stay inline in the top module.

Test Plan:
(All scenarios use NPINS=8, SETTLE=2, IDXW=4.)
- Clean loopback RCV=DRV, MODE=0, START at cycle 0 -> DONE pulse at cycle 25, PASS=1, FAULT_CNT=0, DRV_OE=0 from cycle 26.
- Open pin 5 (RCV[5]=0 always), MODE=0 -> FAULT_CNT=1, FIRST_IDX=5, FIRST_DIFF=8'h20, PASS=0.
- Pins 2,3 shorted wired-OR, MODE=0 -> FAULT_CNT=2, FIRST_IDX=2, FIRST_DIFF=8'h08.
- Pins 2,3 shorted wired-AND, MODE=1 -> step 2 drives 8'hFB and receives 8'hF3; FAULT_CNT=2, FIRST_IDX=2, FIRST_DIFF=8'h08.
- ABORT at cycle 7 and a START pulse at cycle 4 -> START at cycle 4 ignored; IDLE at cycle 8 with BUSY=0 and DRV=0; no DONE pulse; PASS=0.
- RESET high at cycle 10 mid-run -> all outputs at reset values in the same cycle, with no clock edge required; a fresh START after release runs a full 25-cycle test.

Source files
------------

// File: rtl/conn_test_pkg.sv
// Shared types and defaults for the connector test models and the loopback tester.
package conn_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_FINISH  = 2'd3
    } conn_state_t;

    localparam logic WALK_ONE  = 1'b0;
    localparam logic WALK_ZERO = 1'b1;

    localparam int NPINS_DEF  = 165;
    localparam int SETTLE_DEF = 4;
    localparam int IDXW_DEF   = 8;

endpackage

// File: rtl/conn_step_timer.sv
// Settle down-counter: loads SETTLE-1, counts to zero while enabled, flags expiry
// on the last settle cycle.
module conn_step_timer
    import conn_test_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(SETTLE - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/conn_loopback_tester.sv
// Walking-one / walking-zero connector loopback tester: drives one pattern per pin,
// compares the looped-back value, and records fault count and first failure.
//
// state      | meaning
// ST_IDLE    | outputs off, waiting for START
// ST_SETTLE  | pattern i driven, waiting SETTLE cycles for loopback
// ST_COMPARE | sample RCV against the driven pattern, advance i
// ST_FINISH  | one-cycle DONE, PASS reflects the completed run
module conn_loopback_tester
    import conn_test_pkg::*;
#(
    parameter int NPINS  = NPINS_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int IDXW   = IDXW_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             abort_i,
    output logic [NPINS-1:0] drv_o,
    output logic             drv_oe_o,
    input  logic [NPINS-1:0] rcv_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [IDXW-1:0]  fault_cnt_o,
    output logic [IDXW-1:0]  first_idx_o,
    output logic [NPINS-1:0] first_diff_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPINS - 1);
    localparam logic [IDXW-1:0] CNT_MAX  = '1;

    conn_state_t      state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [IDXW-1:0]  fcnt_q, fcnt_d;
    logic [IDXW-1:0]  fidx_q, fidx_d;
    logic [NPINS-1:0] fdiff_q, fdiff_d;
    logic             pass_q, pass_d;

    logic             timer_load;
    logic             timer_expire;
    logic [NPINS-1:0] pattern;
    logic [NPINS-1:0] diff;
    logic             driving;

    conn_step_timer #(
        .SETTLE (SETTLE)
    ) u_step_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (timer_load),
        .en_i     (state_q == ST_SETTLE),
        .expire_o (timer_expire)
    );

    always_comb begin
        pattern = NPINS'(1) << idx_q;
        if (mode_q == WALK_ZERO) begin
            pattern = ~pattern;
        end
    end

    assign driving = (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
    assign diff    = rcv_i ^ pattern;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        fidx_d     = fidx_q;
        fdiff_d    = fdiff_q;
        pass_d     = pass_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d     = mode_i;
                    idx_d      = '0;
                    fcnt_d     = '0;
                    fidx_d     = '0;
                    fdiff_d    = '0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (timer_expire) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (abort_i) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    // fcnt_q is zero exactly until the first failure since it saturates.
                    if (diff != '0) begin
                        if (fcnt_q == '0) begin
                            fidx_d  = idx_q;
                            fdiff_d = diff;
                        end
                        if (fcnt_q != CNT_MAX) begin
                            fcnt_d = fcnt_q + IDXW'(1);
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        pass_d  = (fcnt_d == '0);
                        state_d = ST_FINISH;
                    end else begin
                        idx_d      = idx_q + IDXW'(1);
                        timer_load = 1'b1;
                        state_d    = ST_SETTLE;
                    end
                end
            end
            ST_FINISH: begin
                if (abort_i) begin
                    pass_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= WALK_ONE;
            idx_q   <= '0;
            fcnt_q  <= '0;
            fidx_q  <= '0;
            fdiff_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            fidx_q  <= fidx_d;
            fdiff_q <= fdiff_d;
            pass_q  <= pass_d;
        end
    end

    assign drv_o        = driving ? pattern : '0;
    assign drv_oe_o     = driving;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_FINISH);
    assign pass_o       = pass_q;
    assign fault_cnt_o  = fcnt_q;
    assign first_idx_o  = fidx_q;
    assign first_diff_o = fdiff_q;

endmodule

// File: tb/tb_conn_loopback_tester.sv
// Loopback tester bench: a faulty-connector channel model feeds RCV from DRV, and the
// expected results are derived in the bench from the walking-pattern rules.
module tb_conn_loopback_tester;

    localparam int NP      = 8;
    localparam int ST      = 2;
    localparam int IW      = 4;
    localparam int STEP_CY = ST + 1;
    localparam int RUN_CY  = NP * STEP_CY + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic          abort;
    logic [NP-1:0] drv;
    logic          oe;
    logic [NP-1:0] rcv;
    logic          busy;
    logic          done;
    logic          pass;
    logic [IW-1:0] fcnt;
    logic [IW-1:0] fidx;
    logic [NP-1:0] fdiff;

    logic [NP-1:0] open_m;
    logic [NP-1:0] stk1_m;
    int            sh_kind;
    int            sh_a;
    int            sh_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conn_loopback_tester #(
        .NPINS  (NP),
        .SETTLE (ST),
        .IDXW   (IW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .mode_i       (mode),
        .abort_i      (abort),
        .drv_o        (drv),
        .drv_oe_o     (oe),
        .rcv_i        (rcv),
        .busy_o       (busy),
        .done_o       (done),
        .pass_o       (pass),
        .fault_cnt_o  (fcnt),
        .first_idx_o  (fidx),
        .first_diff_o (fdiff)
    );

    // Connector under test: optional two-pin short (1 = wired-OR, 2 = wired-AND),
    // then open pins read 0 and stuck pins read 1.
    function automatic logic [NP-1:0] channel(input logic [NP-1:0] d, input logic [NP-1:0] om,
                                              input logic [NP-1:0] s1, input int kind,
                                              input int a, input int b);
        logic [NP-1:0] r;
        logic          x;
        r = d;
        if (kind != 0) begin
            x = (kind == 1) ? (d[a] | d[b]) : (d[a] & d[b]);
            r[a] = x;
            r[b] = x;
        end
        return (r & ~om) | s1;
    endfunction

    assign rcv = channel(drv, open_m, stk1_m, sh_kind, sh_a, sh_b);

    function automatic logic [NP-1:0] walk(input logic m, input int s);
        logic [NP-1:0] p;
        p = '0;
        p[s] = 1'b1;
        return m ? ~p : p;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_full(input logic m, input string tag);
        logic [NP-1:0] d;
        int            e_cnt;
        int            e_idx;
        logic [NP-1:0] e_diff;
        int            done_at;
        int            bad;
        e_cnt  = 0;
        e_idx  = 0;
        e_diff = '0;
        for (int s = 0; s < NP; s++) begin
            d = channel(walk(m, s), open_m, stk1_m, sh_kind, sh_a, sh_b) ^ walk(m, s);
            if (d != '0) begin
                if (e_cnt == 0) begin
                    e_idx  = s;
                    e_diff = d;
                end
                if (e_cnt < (1 << IW) - 1) e_cnt++;
            end
        end

        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at = 0;
        bad = 0;
        for (int c = 1; c <= RUN_CY + 5 && done_at == 0; c++) begin
            if (c <= NP * STEP_CY) begin
                if (drv !== walk(m, (c - 1) / STEP_CY) || oe !== 1'b1 || busy !== 1'b1) bad++;
            end
            if (done === 1'b1) done_at = c;
            else tick();
        end
        check({tag, "_drv_timeline_bad"}, bad, 0);
        check({tag, "_done_cycle"}, done_at, RUN_CY);
        check({tag, "_finish_oe"}, {31'd0, oe}, 0);
        check({tag, "_pass"}, {31'd0, pass}, (e_cnt == 0) ? 1 : 0);
        check({tag, "_fault_cnt"}, {28'd0, fcnt}, e_cnt);
        check({tag, "_first_idx"}, {28'd0, fidx}, e_idx);
        check({tag, "_first_diff"}, {24'd0, fdiff}, {24'd0, e_diff});
        tick();
        check({tag, "_after_idle"}, {29'd0, done, oe, busy}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        abort = 1'b0;
        open_m = '0;
        stk1_m = '0;
        sh_kind = 0;
        sh_a = 0;
        sh_b = 1;
        tick();
        tick();
        check("reset_outputs", {27'd0, drv != '0, oe, busy, done, pass}, 0);
        check("reset_results", {fcnt, fidx, fdiff}, 0);
        rst = 1'b0;
        tick();

        run_full(1'b0, "clean_w1");

        open_m = 8'h20;
        run_full(1'b0, "open5_w1");
        open_m = '0;

        sh_kind = 1; sh_a = 2; sh_b = 3;
        run_full(1'b0, "short_or_w1");
        sh_kind = 2;
        run_full(1'b1, "short_and_w0");
        sh_kind = 0;

        // Abort at cycle 7 with a stray START at cycle 4; pin 0 open gives a partial count.
        open_m = 8'h01;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("abort_stray_start_drv", {24'd0, drv}, 32'h04);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_outputs", {27'd0, drv != '0, oe, busy, done, pass}, 0);
        check("abort_partial", {fcnt, fidx, fdiff}, {4'd1, 4'd0, 8'h01});
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        check("abort_no_done", seen, 0);

        // Abort during the compare of a failing step must suppress that update.
        open_m = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_vs_compare", {26'd0, busy, pass, fcnt}, 0);

        // Asynchronous reset at cycle 10 of a run with one fault already counted.
        open_m = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre_reset_cnt", {28'd0, fcnt}, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {27'd0, drv != '0, oe, busy, done, pass}, 0);
        check("async_reset_results", {fcnt, fidx, fdiff}, 0);
        tick();
        rst = 1'b0;
        tick();
        open_m = '0;
        run_full(1'b0, "post_reset");

        for (int k = 0; k < 6; k++) begin
            open_m  = NP'($urandom & $urandom);
            stk1_m  = NP'($urandom & $urandom & $urandom);
            sh_kind = $urandom_range(0, 2);
            sh_a    = $urandom_range(0, NP - 1);
            sh_b    = $urandom_range(0, NP - 1);
            run_full(1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
